// File: rtl/sys_ctrl_if.sv
// sys_ctrl_if: bus between the UART command controller and its RX/TX, register file and ALU neighbours.
interface sys_ctrl_if #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 4,
  parameter int FUN_W     = 4,
  parameter int ALU_OUT_W = 16
);
  logic [DATA_W-1:0]    RX_P_DATA;
  logic                 RX_D_VLD;
  logic [DATA_W-1:0]    RdData;
  logic                 RdData_Valid;
  logic [ALU_OUT_W-1:0] ALU_OUT;
  logic                 OUT_Valid;
  logic                 TX_BUSY;
  logic                 ALU_EN;
  logic [FUN_W-1:0]     ALU_FUN;
  logic                 CLK_EN;
  logic [ADDR_W-1:0]    Address;
  logic                 WrEn;
  logic                 RdEn;
  logic [DATA_W-1:0]    WrData;
  logic [DATA_W-1:0]    TX_P_DATA;
  logic                 TX_D_VLD;
  logic                 clk_div_en;
  logic                 FRAME_ERR;
  modport master (
    input  RX_P_DATA, RX_D_VLD, RdData, RdData_Valid, ALU_OUT, OUT_Valid, TX_BUSY,
    output ALU_EN, ALU_FUN, CLK_EN, Address, WrEn, RdEn, WrData, TX_P_DATA, TX_D_VLD,
           clk_div_en, FRAME_ERR
  );
  modport slave (
    output RX_P_DATA, RX_D_VLD, RdData, RdData_Valid, ALU_OUT, OUT_Valid, TX_BUSY,
    input  ALU_EN, ALU_FUN, CLK_EN, Address, WrEn, RdEn, WrData, TX_P_DATA, TX_D_VLD,
           clk_div_en, FRAME_ERR
  );
endinterface

// File: rtl/sys_ctrl_gen.sv
// sys_ctrl_gen: decodes framed UART commands into register-file writes/reads and ALU operations,
// returning read data and ALU results over UART_TX, LSB byte first.
module sys_ctrl_gen #(
  parameter int                 DATA_W    = 8,
  parameter int                 ADDR_W    = 4,
  parameter int                 FUN_W     = 4,
  parameter int                 ALU_OUT_W = 16,
  parameter logic [2**FUN_W-1:0] WIDE_MASK = 16'h0004,
  parameter int                 TIMEOUT   = 1023,
  parameter logic [DATA_W-1:0]  CMD_WR    = 8'hAA,
  parameter logic [DATA_W-1:0]  CMD_RD    = 8'hBB,
  parameter logic [DATA_W-1:0]  CMD_OP    = 8'hCC,
  parameter logic [DATA_W-1:0]  CMD_NOP   = 8'hDD
) (
  input logic       CLK,
  input logic       RST,
  sys_ctrl_if.master bus
);
  localparam int NBYTES = ALU_OUT_W / DATA_W;
  localparam int CW     = $clog2(NBYTES + 1);
  localparam int TW     = $clog2(TIMEOUT + 2);

  typedef enum logic [3:0] {
    IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, OP_A, OP_B, FUN, ALU_WAIT, TX_SEND
  } state_t;

  state_t               state_q, state_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [DATA_W-1:0]    wdata_q, wdata_d;
  logic                 wr_en_q, wr_en_d;
  logic                 rd_en_q, rd_en_d;
  logic                 alu_en_q, alu_en_d;
  logic [FUN_W-1:0]     fun_q, fun_d;
  logic                 clk_en_q, clk_en_d;
  logic [ALU_OUT_W-1:0] buf_q, buf_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0]    tx_data_q, tx_data_d;
  logic                 tx_vld_q, tx_vld_d;
  logic                 err_q, err_d;
  logic                 div_en_q, div_en_d;
  logic [TW-1:0]        tmo_q, tmo_d;

  logic              rx, is_cmd, strobe, tmo_run, tmo_hit, send, rd_load, alu_load, wr_fire, alu_go;
  logic [DATA_W-1:0] b;

  always_comb begin
    rx       = bus.RX_D_VLD;
    b        = bus.RX_P_DATA;
    is_cmd   = b == CMD_WR || b == CMD_RD || b == CMD_OP || b == CMD_NOP;
    strobe   = rx || bus.RdData_Valid || bus.OUT_Valid;
    tmo_run  = state_q != IDLE && state_q != TX_SEND;
    tmo_hit  = TIMEOUT != 0 && tmo_run && !strobe && tmo_q == TW'(TIMEOUT - 1);
    // one idle cycle after every strobe guarantees the 2-cycle minimum spacing
    send     = state_q == TX_SEND && !bus.TX_BUSY && !tx_vld_q;
    rd_load  = state_q == RD_WAIT && bus.RdData_Valid;
    alu_load = state_q == ALU_WAIT && bus.OUT_Valid;
    wr_fire  = rx && (state_q == WR_DATA || state_q == OP_A || state_q == OP_B);
    alu_go   = rx && state_q == FUN;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      wr_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      alu_en_q  <= 1'b0;
      fun_q     <= '0;
      clk_en_q  <= 1'b0;
      buf_q     <= '0;
      cnt_q     <= '0;
      tx_data_q <= '0;
      tx_vld_q  <= 1'b0;
      err_q     <= 1'b0;
      div_en_q  <= 1'b0;
      tmo_q     <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wr_en_q   <= wr_en_d;
      rd_en_q   <= rd_en_d;
      alu_en_q  <= alu_en_d;
      fun_q     <= fun_d;
      clk_en_q  <= clk_en_d;
      buf_q     <= buf_d;
      cnt_q     <= cnt_d;
      tx_data_q <= tx_data_d;
      tx_vld_q  <= tx_vld_d;
      err_q     <= err_d;
      div_en_q  <= div_en_d;
      tmo_q     <= tmo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (rx) state_d = b == CMD_WR ? WR_ADDR : b == CMD_RD ? RD_ADDR :
                                  b == CMD_OP ? OP_A : b == CMD_NOP ? FUN : IDLE;
      WR_ADDR:  if (rx) state_d = WR_DATA;
      WR_DATA:  if (rx) state_d = IDLE;
      RD_ADDR:  if (rx) state_d = RD_WAIT;
      RD_WAIT:  if (bus.RdData_Valid) state_d = TX_SEND;
      OP_A:     if (rx) state_d = OP_B;
      OP_B:     if (rx) state_d = FUN;
      FUN:      if (rx) state_d = ALU_WAIT;
      ALU_WAIT: if (bus.OUT_Valid) state_d = TX_SEND;
      TX_SEND:  if (send && cnt_q == CW'(1)) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
    if (tmo_hit) state_d = IDLE;
  end

  always_comb begin
    addr_d    = (rx && (state_q == WR_ADDR || state_q == RD_ADDR)) ? b[ADDR_W-1:0] :
                (rx && state_q == OP_B) ? ADDR_W'(1) :
                (rx && (state_q == OP_A || (state_q == IDLE && b == CMD_OP))) ? '0 : addr_q;
    wdata_d   = wr_fire ? b : wdata_q;
    wr_en_d   = wr_fire;
    rd_en_d   = rx && state_q == RD_ADDR;
    alu_en_d  = alu_go;
    fun_d     = alu_go ? b[FUN_W-1:0] : fun_q;
    // the ALU clock stays on until its result has been fully shifted out
    clk_en_d  = state_d == FUN || state_d == ALU_WAIT || (state_d == TX_SEND && clk_en_q);
    buf_d     = rd_load ? ALU_OUT_W'(bus.RdData) : alu_load ? bus.ALU_OUT :
                send ? buf_q >> DATA_W : buf_q;
    cnt_d     = rd_load ? CW'(1) : alu_load ? (WIDE_MASK[fun_q] ? CW'(NBYTES) : CW'(1)) :
                send ? cnt_q - CW'(1) : cnt_q;
    tx_data_d = send ? buf_q[DATA_W-1:0] : tx_data_q;
    tx_vld_d  = send;
    err_d     = (rx && state_q == IDLE && !is_cmd) ||
                (rx && (state_q == RD_WAIT || state_q == ALU_WAIT || state_q == TX_SEND)) || tmo_hit;
    div_en_d  = 1'b1;
    tmo_d     = (!tmo_run || strobe || state_d != state_q) ? '0 : tmo_q + TW'(1);
  end

  assign bus.ALU_EN     = alu_en_q;
  assign bus.ALU_FUN    = fun_q;
  assign bus.CLK_EN     = clk_en_q;
  assign bus.Address    = addr_q;
  assign bus.WrEn       = wr_en_q;
  assign bus.RdEn       = rd_en_q;
  assign bus.WrData     = wdata_q;
  assign bus.TX_P_DATA  = tx_data_q;
  assign bus.TX_D_VLD   = tx_vld_q;
  assign bus.clk_div_en = div_en_q;
  assign bus.FRAME_ERR  = err_q;
endmodule

// File: tb/tb_sys_ctrl_gen.sv
// tb_sys_ctrl_gen: directed frames against sys_ctrl_gen with hand-computed expectations.
module tb_sys_ctrl_gen;
  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  sys_ctrl_if bus ();
  sys_ctrl_gen dut (.CLK(CLK), .RST(RST), .bus(bus));

  int errors = 0;
  int checks = 0;
  int wr_n = 0, rd_n = 0, alu_n = 0, err_n = 0, gap_viol = 0, busy_viol = 0;
  logic prev_vld = 1'b0;
  logic [7:0]  txq[$];
  logic [11:0] wlog[$];

  always @(posedge CLK) begin
    #1;
    if (bus.WrEn) begin
      wr_n++;
      wlog.push_back({bus.Address, bus.WrData});
    end
    if (bus.RdEn) rd_n++;
    if (bus.ALU_EN) alu_n++;
    if (bus.FRAME_ERR) err_n++;
    if (bus.TX_D_VLD) begin
      txq.push_back(bus.TX_P_DATA);
      if (prev_vld) gap_viol++;
      if (bus.TX_BUSY) busy_viol++;
    end
    prev_vld = bus.TX_D_VLD;
  end

  function automatic logic [30:0] outs();
    return {bus.ALU_EN, bus.ALU_FUN, bus.CLK_EN, bus.Address, bus.WrEn, bus.RdEn, bus.WrData,
            bus.TX_P_DATA, bus.TX_D_VLD, bus.clk_div_en, bus.FRAME_ERR};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic send_byte(input logic [7:0] v);
    @(negedge CLK);
    bus.RX_P_DATA = v;
    bus.RX_D_VLD  = 1'b1;
    @(negedge CLK);
    bus.RX_D_VLD  = 1'b0;
  endtask

  task automatic pulse_rd(input logic [7:0] v);
    @(negedge CLK);
    bus.RdData       = v;
    bus.RdData_Valid = 1'b1;
    @(negedge CLK);
    bus.RdData_Valid = 1'b0;
  endtask

  task automatic pulse_alu(input logic [15:0] v);
    @(negedge CLK);
    bus.ALU_OUT   = v;
    bus.OUT_Valid = 1'b1;
    @(negedge CLK);
    bus.OUT_Valid = 1'b0;
  endtask

  task automatic wait_tx(input int want, input int budget);
    for (int i = 0; i < budget && txq.size() < want; i++) @(negedge CLK);
  endtask

  task automatic test_reset();
    bus.RX_P_DATA = '0; bus.RX_D_VLD = 0; bus.RdData = '0; bus.RdData_Valid = 0;
    bus.ALU_OUT = '0; bus.OUT_Valid = 0; bus.TX_BUSY = 0;
    RST = 1'b0;
    tick(3);
    checks++;
    if (outs() !== 31'd0) begin errors++; $display("FAIL reset_outputs: got %h want 0", outs()); end
    RST = 1'b1;
    tick(1);
    checks++;
    if (bus.clk_div_en !== 1'b1) begin errors++; $display("FAIL clk_div_en: got %b want 1", bus.clk_div_en); end
  endtask

  task automatic test_write();
    int w0 = wr_n, e0 = err_n;
    send_byte(8'hAA);
    send_byte(8'h05);
    checks++;
    if (bus.WrEn !== 1'b0 || bus.Address !== 4'h5) begin
      errors++; $display("FAIL wr_addr: got WrEn=%b Address=%h want 0/5", bus.WrEn, bus.Address);
    end
    send_byte(8'h3C);
    checks++;
    if ({bus.WrEn, bus.Address, bus.WrData} !== {1'b1, 4'h5, 8'h3C}) begin
      errors++; $display("FAIL wr_pulse: got %b/%h/%h want 1/5/3c", bus.WrEn, bus.Address, bus.WrData);
    end
    tick(1);
    checks++;
    if (bus.WrEn !== 1'b0) begin errors++; $display("FAIL wr_one_cycle: got WrEn=%b want 0", bus.WrEn); end
    checks++;
    if (wr_n - w0 != 1 || err_n - e0 != 0) begin
      errors++; $display("FAIL wr_counts: got writes=%0d errs=%0d want 1/0", wr_n - w0, err_n - e0);
    end
  endtask

  task automatic test_read();
    int t0 = txq.size(), r0 = rd_n;
    send_byte(8'hBB);
    send_byte(8'h05);
    checks++;
    if (bus.RdEn !== 1'b1 || bus.Address !== 4'h5) begin
      errors++; $display("FAIL rd_pulse: got RdEn=%b Address=%h want 1/5", bus.RdEn, bus.Address);
    end
    tick(3);
    pulse_rd(8'h3C);
    wait_tx(t0 + 1, 20);
    tick(5);
    checks++;
    if (txq.size() - t0 != 1 || rd_n - r0 != 1) begin
      errors++; $display("FAIL rd_counts: got tx=%0d rden=%0d want 1/1", txq.size() - t0, rd_n - r0);
    end else begin
      checks++;
      if (txq[t0] !== 8'h3C) begin errors++; $display("FAIL rd_tx_byte: got %h want 3c", txq[t0]); end
    end
  endtask

  task automatic test_alu();
    int t0 = txq.size(), w0 = wlog.size(), a0 = alu_n;
    send_byte(8'hCC);
    send_byte(8'h07);
    send_byte(8'h09);
    send_byte(8'h02);
    checks++;
    if ({bus.ALU_EN, bus.ALU_FUN, bus.CLK_EN} !== {1'b1, 4'h2, 1'b1}) begin
      errors++; $display("FAIL alu_start: got %b/%h/%b want 1/2/1", bus.ALU_EN, bus.ALU_FUN, bus.CLK_EN);
    end
    checks++;
    if (wlog.size() - w0 != 2) begin
      errors++; $display("FAIL op_writes: got %0d want 2", wlog.size() - w0);
    end else begin
      checks++;
      if (wlog[w0] !== 12'h007 || wlog[w0+1] !== 12'h109) begin
        errors++; $display("FAIL op_operands: got %h %h want 007 109", wlog[w0], wlog[w0+1]);
      end
    end
    tick(3);
    checks++;
    if (bus.CLK_EN !== 1'b1 || bus.ALU_EN !== 1'b0) begin
      errors++; $display("FAIL alu_wait: got CLK_EN=%b ALU_EN=%b want 1/0", bus.CLK_EN, bus.ALU_EN);
    end
    pulse_alu(16'h003F);
    wait_tx(t0 + 2, 20);
    tick(3);
    checks++;
    if (txq.size() - t0 != 2) begin
      errors++; $display("FAIL alu_tx_count: got %0d want 2", txq.size() - t0);
    end else begin
      checks++;
      if (txq[t0] !== 8'h3F || txq[t0+1] !== 8'h00) begin
        errors++; $display("FAIL alu_tx_bytes: got %h %h want 3f 00", txq[t0], txq[t0+1]);
      end
    end
    checks++;
    if (gap_viol != 0 || bus.CLK_EN !== 1'b0 || alu_n - a0 != 1) begin
      errors++; $display("FAIL alu_end: got gaps=%0d CLK_EN=%b alu_en=%0d want 0/0/1", gap_viol, bus.CLK_EN, alu_n - a0);
    end
  endtask

  task automatic test_busy();
    int t0 = txq.size();
    bus.TX_BUSY = 1'b1;
    send_byte(8'hDD);
    send_byte(8'h00);
    pulse_alu(16'h0010);
    tick(20);
    checks++;
    if (txq.size() != t0) begin errors++; $display("FAIL busy_hold: got %0d strobes want 0", txq.size() - t0); end
    bus.TX_BUSY = 1'b0;
    wait_tx(t0 + 1, 20);
    tick(5);
    checks++;
    if (txq.size() - t0 != 1 || busy_viol != 0) begin
      errors++; $display("FAIL busy_tx: got %0d strobes viol=%0d want 1/0", txq.size() - t0, busy_viol);
    end else begin
      checks++;
      if (txq[t0] !== 8'h10) begin errors++; $display("FAIL busy_byte: got %h want 10", txq[t0]); end
    end
  endtask

  task automatic test_unknown();
    int e0 = err_n;
    send_byte(8'h12);
    checks++;
    if (bus.FRAME_ERR !== 1'b1) begin errors++; $display("FAIL unknown_err: got %b want 1", bus.FRAME_ERR); end
    tick(1);
    checks++;
    if (bus.FRAME_ERR !== 1'b0 || err_n - e0 != 1) begin
      errors++; $display("FAIL unknown_pulse: got %b count=%0d want 0/1", bus.FRAME_ERR, err_n - e0);
    end
  endtask

  task automatic test_timeout();
    int w0 = wr_n, e0 = err_n;
    send_byte(8'hAA);
    send_byte(8'h05);
    tick(1000);
    checks++;
    if (err_n - e0 != 0) begin errors++; $display("FAIL timeout_early: got %0d errs want 0", err_n - e0); end
    tick(40);
    checks++;
    if (err_n - e0 != 1 || wr_n - w0 != 0) begin
      errors++; $display("FAIL timeout_fire: got errs=%0d writes=%0d want 1/0", err_n - e0, wr_n - w0);
    end
    send_byte(8'h3C);
    checks++;
    if (bus.FRAME_ERR !== 1'b1 || bus.WrEn !== 1'b0) begin
      errors++; $display("FAIL timeout_idle: got FRAME_ERR=%b WrEn=%b want 1/0", bus.FRAME_ERR, bus.WrEn);
    end
  endtask

  task automatic test_drop();
    int t0 = txq.size();
    send_byte(8'hBB);
    send_byte(8'h03);
    send_byte(8'h77);
    checks++;
    if (bus.FRAME_ERR !== 1'b1) begin errors++; $display("FAIL drop_err: got %b want 1", bus.FRAME_ERR); end
    pulse_rd(8'h5A);
    wait_tx(t0 + 1, 20);
    tick(5);
    checks++;
    if (txq.size() - t0 != 1) begin
      errors++; $display("FAIL drop_tx: got %0d strobes want 1", txq.size() - t0);
    end else begin
      checks++;
      if (txq[t0] !== 8'h5A) begin errors++; $display("FAIL drop_byte: got %h want 5a", txq[t0]); end
    end
  endtask

  task automatic test_reset_mid_tx();
    int t0 = txq.size();
    send_byte(8'hCC);
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h02);
    pulse_alu(16'hABCD);
    wait_tx(t0 + 1, 20);
    RST = 1'b0;
    #1;
    checks++;
    if (outs() !== 31'd0) begin errors++; $display("FAIL mid_reset_outputs: got %h want 0", outs()); end
    tick(3);
    RST = 1'b1;
    tick(4);
    checks++;
    if (txq.size() - t0 != 1) begin
      errors++; $display("FAIL mid_reset_tx: got %0d strobes want 1", txq.size() - t0);
    end else begin
      checks++;
      if (txq[t0] !== 8'hCD) begin errors++; $display("FAIL mid_reset_byte: got %h want cd", txq[t0]); end
    end
  endtask

  task automatic test_back_to_back();
    send_byte(8'hAA);
    send_byte(8'h0A);
    send_byte(8'hE1);
    checks++;
    if ({bus.WrEn, bus.Address, bus.WrData} !== {1'b1, 4'hA, 8'hE1}) begin
      errors++; $display("FAIL b2b_first: got %b/%h/%h want 1/a/e1", bus.WrEn, bus.Address, bus.WrData);
    end
    bus.RX_P_DATA = 8'hAA; bus.RX_D_VLD = 1'b1; tick(1);
    bus.RX_P_DATA = 8'h06; tick(1);
    bus.RX_P_DATA = 8'h42; tick(1);
    bus.RX_D_VLD = 1'b0;
    checks++;
    if ({bus.WrEn, bus.Address, bus.WrData} !== {1'b1, 4'h6, 8'h42}) begin
      errors++; $display("FAIL b2b_second: got %b/%h/%h want 1/6/42", bus.WrEn, bus.Address, bus.WrData);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_alu();
    test_busy();
    test_unknown();
    test_timeout();
    test_drop();
    test_reset_mid_tx();
    test_back_to_back();
    tick(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
